irq_select_encoder16: RTL and testbench

- Sixteen-line interrupt/request encoder: latches rising edges on 16 request lines into a pending register and picks the highest-priority unmasked pending line.
- Presents the winner as an 8-bit Selector code with a valid/ack handshake.
- Is the producing end of the 16-way selector-decode path: its Selector output feeds the 8-bit selector decoder of the LEG call/ret dispatch logic, which regenerates the one-hot line.

---
 rtl/irq_select_encoder16.sv | 143 ++++++++++++++
 tb/tb_irq_select_encoder16.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_select_encoder16.sv
// irq_select_encoder16
//
// Sixteen-line request encoder. It latches rising edges of Request into a
// pending register, then picks the lowest-index pending line that is not
// masked. The winner is presented as an 8-bit Selector code with a
// Valid/Ack handshake. The code is chosen so that the downstream 8-bit
// selector decoder regenerates one-hot line k+1 for request bit k.
//
// State | Meaning
// ------+--------------------------------------------------------------
// IDLE  | Nothing presented; look for an eligible pending line
// PRESENT | Selector/index frozen, Valid=1, waiting for Ack
// GAP   | One forced Valid=0 cycle between consecutive codes
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   Request   request lines (edge sensitive)
//   Mask      1 = line excluded from selection (it still pends)
//   Disable   1 = no new selection is started
//   Ack       consumer accepts the presented Selector
//   Valid     Selector holds a pending, unacknowledged code
//   Selector  encoded line code, bits 7:4 always 0
//   Pending   pending register readback

module irq_select_encoder16 #(
  parameter int    UUID = 0,
  parameter string NAME = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Request,
  input  logic [15:0] Mask,
  input  logic        Disable,
  input  logic        Ack,
  output logic        Valid,
  output logic [7:0]  Selector,
  output logic [15:0] Pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] prev_q, prev_d;
  logic [15:0] pending_q, pending_d;
  logic [7:0]  sel_q, sel_d;
  logic [3:0]  idx_q, idx_d;
  logic        valid_q, valid_d;

  logic [15:0] rise;
  logic [15:0] eligible;
  logic [15:0] clr;
  logic [3:0]  win_idx;
  logic        win_found;

  // Line k maps to code 7-k (k<8) or 23-k (k>=8). Both reduce to keeping
  // bit 3 of the index and inverting the low three bits.
  function automatic logic [7:0] line_code(input logic [3:0] idx);
    return {4'h0, idx[3], ~idx[2:0]};
  endfunction

  always_comb begin
    rise     = Request & ~prev_q;
    eligible = pending_q & ~Mask;

    // Descending scan so the lowest set index is the one left standing.
    win_idx   = 4'd0;
    win_found = 1'b0;
    for (int k = 15; k >= 0; k--) begin
      if (eligible[k]) begin
        win_idx   = 4'(k);
        win_found = 1'b1;
      end
    end

    clr = 16'h0000;
    if (state_q == PRESENT && Ack) begin
      clr[idx_q] = 1'b1;
    end

    // A new edge in the same cycle as the clear wins, so the line re-pends.
    pending_d = (pending_q & ~clr) | rise;
    prev_d    = Request;

    state_d = state_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    idx_d   = idx_q;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (!Disable && win_found) begin
          sel_d   = line_code(win_idx);
          idx_d   = win_idx;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (Ack) begin
          valid_d = 1'b0;
          state_d = (|(pending_d & ~Mask)) ? GAP : IDLE;
        end
      end
      GAP: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      prev_q    <= 16'h0000;
      pending_q <= 16'h0000;
      sel_q     <= 8'h00;
      idx_q     <= 4'd0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
    end
  end

  assign Valid    = valid_q;
  assign Selector = sel_q;
  assign Pending  = pending_q;

endmodule

// File: tb/tb_irq_select_encoder16.sv
module tb_irq_select_encoder16;

  logic        clk;
  logic        rst;
  logic [15:0] Request;
  logic [15:0] Mask;
  logic        Disable;
  logic        Ack;
  logic        Valid;
  logic [7:0]  Selector;
  logic [15:0] Pending;

  int n_tests;
  int n_fail;
  logic [7:0] exp_q[$];

  irq_select_encoder16 #(.UUID(0), .NAME("tb")) dut (
    .clk      (clk),
    .rst      (rst),
    .Request  (Request),
    .Mask     (Mask),
    .Disable  (Disable),
    .Ack      (Ack),
    .Valid    (Valid),
    .Selector (Selector),
    .Pending  (Pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse(input logic [15:0] req);
    Request = req;
    step();
    Request = 16'h0000;
  endtask

  task automatic do_ack();
    Ack = 1'b1;
    step();
    Ack = 1'b0;
  endtask

  // Waits (bounded) for Valid; reports success through ok.
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (Valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  function automatic logic [7:0] pop_exp();
    if (exp_q.size() == 0) return 8'hFF;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    logic [7:0] e;
    rst = 1'b0; Request = 16'h0001; Mask = 16'h0000; Disable = 1'b0; Ack = 1'b0;
    step(); step();
    n_tests++;
    if (Valid !== 1'b0 || Selector !== 8'h00 || Pending !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_state: got V=%b S=%h P=%h expected V=0 S=00 P=0000", Valid, Selector, Pending);
    end
    rst = 1'b1;
    exp_q.push_back(8'h07);
    step();
    n_tests++;
    if (Pending !== 16'h0001 || Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_edge: got P=%h V=%b expected P=0001 V=0", Pending, Valid);
    end
    step();
    e = pop_exp();
    n_tests++;
    if (Valid !== 1'b1 || Selector !== e) begin
      n_fail++;
      $display("FAIL reset_present: got V=%b S=%h expected V=1 S=%h", Valid, Selector, e);
    end
    do_ack();
    Request = 16'h0000;
    n_tests++;
    if (Valid !== 1'b0 || Pending !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_ack: got V=%b P=%h expected V=0 P=0000", Valid, Pending);
    end
    step();
  endtask

  task automatic test_two_lines();
    bit ok;
    logic [7:0] e;
    pulse(16'h1008);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h0B);
    wait_valid(ok);
    e = pop_exp();
    n_tests++;
    if (!ok || Selector !== e) begin
      n_fail++;
      $display("FAIL two_first: got ok=%b S=%h expected S=%h", ok, Selector, e);
    end
    do_ack();
    n_tests++;
    if (Valid !== 1'b0 || Pending !== 16'h1000) begin
      n_fail++;
      $display("FAIL two_gap: got V=%b P=%h expected V=0 P=1000", Valid, Pending);
    end
    wait_valid(ok);
    e = pop_exp();
    n_tests++;
    if (!ok || Selector !== e) begin
      n_fail++;
      $display("FAIL two_second: got ok=%b S=%h expected S=%h", ok, Selector, e);
    end
    do_ack();
    n_tests++;
    if (Valid !== 1'b0 || Pending !== 16'h0000) begin
      n_fail++;
      $display("FAIL two_done: got V=%b P=%h expected V=0 P=0000", Valid, Pending);
    end
    step();
  endtask

  task automatic test_mask();
    bit ok;
    logic [7:0] e;
    Mask = 16'h0001;
    pulse(16'h0201);
    exp_q.push_back(8'h0E);
    exp_q.push_back(8'h07);
    wait_valid(ok);
    e = pop_exp();
    n_tests++;
    if (!ok || Selector !== e || Pending[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL mask_first: got ok=%b S=%h P=%h expected S=%h P[0]=1", ok, Selector, Pending, e);
    end
    Mask = 16'h0000;
    step();
    n_tests++;
    if (Valid !== 1'b1 || Selector !== 8'h0E) begin
      n_fail++;
      $display("FAIL mask_frozen: got V=%b S=%h expected V=1 S=0e", Valid, Selector);
    end
    do_ack();
    wait_valid(ok);
    e = pop_exp();
    n_tests++;
    if (!ok || Selector !== e) begin
      n_fail++;
      $display("FAIL mask_second: got ok=%b S=%h expected S=%h", ok, Selector, e);
    end
    do_ack();
    step();
  endtask

  task automatic test_disable();
    logic [7:0] e;
    Disable = 1'b1;
    pulse(16'h8000);
    exp_q.push_back(8'h08);
    step(); step(); step();
    n_tests++;
    if (Valid !== 1'b0 || Pending !== 16'h8000) begin
      n_fail++;
      $display("FAIL dis_blocked: got V=%b P=%h expected V=0 P=8000", Valid, Pending);
    end
    Disable = 1'b0;
    step();
    e = pop_exp();
    n_tests++;
    if (Valid !== 1'b1 || Selector !== e) begin
      n_fail++;
      $display("FAIL dis_release: got V=%b S=%h expected V=1 S=%h", Valid, Selector, e);
    end
    Disable = 1'b1;
    step(); step(); step();
    n_tests++;
    if (Valid !== 1'b1 || Selector !== 8'h08) begin
      n_fail++;
      $display("FAIL dis_hold: got V=%b S=%h expected V=1 S=08", Valid, Selector);
    end
    do_ack();
    Disable = 1'b0;
    n_tests++;
    if (Valid !== 1'b0 || Pending !== 16'h0000) begin
      n_fail++;
      $display("FAIL dis_ack: got V=%b P=%h expected V=0 P=0000", Valid, Pending);
    end
    step();
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] e;
    pulse(16'h0020);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h02);
    wait_valid(ok);
    e = pop_exp();
    n_tests++;
    if (!ok || Selector !== e) begin
      n_fail++;
      $display("FAIL b2b_first: got ok=%b S=%h expected S=%h", ok, Selector, e);
    end
    Request = 16'h0020;
    Ack = 1'b1;
    step();
    Ack = 1'b0;
    Request = 16'h0000;
    n_tests++;
    if (Valid !== 1'b0 || Pending !== 16'h0020) begin
      n_fail++;
      $display("FAIL b2b_setwins: got V=%b P=%h expected V=0 P=0020", Valid, Pending);
    end
    step();
    n_tests++;
    if (Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: got V=%b expected V=0", Valid);
    end
    wait_valid(ok);
    e = pop_exp();
    n_tests++;
    if (!ok || Selector !== e) begin
      n_fail++;
      $display("FAIL b2b_again: got ok=%b S=%h expected S=%h", ok, Selector, e);
    end
    do_ack();
    step();
  endtask

  task automatic test_ack_idle_and_hold();
    bit ok;
    logic [7:0] e;
    Mask = 16'h0002;
    pulse(16'h0002);
    step();
    do_ack();
    n_tests++;
    if (Valid !== 1'b0 || Pending !== 16'h0002) begin
      n_fail++;
      $display("FAIL ack_idle: got V=%b P=%h expected V=0 P=0002", Valid, Pending);
    end
    Mask = 16'h0000;
    exp_q.push_back(8'h06);
    wait_valid(ok);
    e = pop_exp();
    n_tests++;
    if (!ok || Selector !== e) begin
      n_fail++;
      $display("FAIL unmask: got ok=%b S=%h expected S=%h", ok, Selector, e);
    end
    do_ack();
    step();
    // A held request must produce exactly one event.
    Request = 16'h0004;
    exp_q.push_back(8'h05);
    step();
    wait_valid(ok);
    e = pop_exp();
    n_tests++;
    if (!ok || Selector !== e) begin
      n_fail++;
      $display("FAIL hold_first: got ok=%b S=%h expected S=%h", ok, Selector, e);
    end
    do_ack();
    for (int i = 0; i < 4; i++) step();
    n_tests++;
    if (Valid !== 1'b0 || Pending !== 16'h0000) begin
      n_fail++;
      $display("FAIL hold_once: got V=%b P=%h expected V=0 P=0000", Valid, Pending);
    end
    Request = 16'h0000;
    step();
  endtask

  task automatic test_async_reset();
    bit ok;
    bit seen;
    logic [7:0] e;
    pulse(16'h0410);
    exp_q.push_back(8'h03);
    wait_valid(ok);
    e = pop_exp();
    n_tests++;
    if (!ok || Selector !== e) begin
      n_fail++;
      $display("FAIL arst_present: got ok=%b S=%h expected S=%h", ok, Selector, e);
    end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (Valid !== 1'b0 || Selector !== 8'h00 || Pending !== 16'h0000) begin
      n_fail++;
      $display("FAIL arst_clear: got V=%b S=%h P=%h expected V=0 S=00 P=0000", Valid, Selector, Pending);
    end
    step();
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (Valid !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0 || Pending !== 16'h0000) begin
      n_fail++;
      $display("FAIL arst_quiet: got seen=%b P=%h expected seen=0 P=0000", seen, Pending);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_two_lines();
    test_mask();
    test_disable();
    test_back_to_back();
    test_ack_idle_and_hold();
    test_async_reset();
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
